// File: rtl/pet_key_sched.sv
//-----------------------------------------------------------------------------
// pet_key_sched
//
// Feeds the UART-to-PET-keyboard block from two requesters: the UART receiver
// (buffered in a small FIFO, strict priority) and an auto-type stream (paste
// buffer / boot script, valid/ready). Each issued byte is held for HOLD_SCANS
// complete PET keyboard scan frames (keyrow 9 -> 0 wraps) before the next
// byte may go out. TIMEOUT_CLKS bounds the wait if the PET stops scanning.
//
// Optional feature, enabled by defining PET_KEY_SCHED_CRLF_EN:
//   a LF (0x0A) directly following an issued CR (0x0D) from the same source
//   is consumed silently; any other LF is issued as CR.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   uart_data    received UART byte
//   uart_strobe  one-cycle valid for uart_data
//   auto_data    auto-type byte
//   auto_valid   auto-type byte available (held until accepted)
//   auto_ready   auto-type byte accepted when auto_valid && auto_ready
//   keyrow       PET keyboard row currently being scanned
//   key_data     byte to the keys block
//   key_strobe   one-cycle strobe to the keys block
//   busy         FIFO non-empty or FSM not idle
//   overflow     sticky: a UART byte was dropped (cleared only by reset)
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//
// Handshake: the auto-type byte transfers on a rising edge where
// auto_valid && auto_ready; auto_data is sampled only on that edge and
// auto_valid must stay high until then.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module pet_key_sched #(
  parameter int FIFO_DEPTH   = 16,
  parameter int HOLD_SCANS   = 3,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_strobe,
  input  logic [7:0] auto_data,
  input  logic       auto_valid,
  output logic       auto_ready,
  input  logic [3:0] keyrow,
  output logic [7:0] key_data,
  output logic       key_strobe,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HOLD_SCANS + 2);
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] HOLD_C   = SW'(HOLD_SCANS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_next;

  //---------------------------------------------------------------------------
  // UART byte FIFO
  //---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [7:0]    fifo_head;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign fifo_head  = mem[rd_ptr];
  // Fullness is judged before this cycle's pop, so a full FIFO drops the
  // byte even if the head is leaving in the same cycle.
  assign push       = uart_strobe && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= uart_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (uart_strobe && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Scan frame wrap detection
  //---------------------------------------------------------------------------
  logic [3:0] prev_keyrow;
  logic       wrap;

  assign wrap = (prev_keyrow == 4'd9) && (keyrow == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_keyrow <= 4'hf;
    end else begin
      prev_keyrow <= keyrow;
    end
  end

  //---------------------------------------------------------------------------
  // Source selection in IDLE
  //---------------------------------------------------------------------------
  logic       take;
  logic [7:0] cand;
  logic       drop;
  logic [7:0] issue_byte;

  // A UART byte arriving this cycle is not yet in the FIFO but already has
  // priority, so it also holds off the auto-type handshake.
  assign auto_ready = (state == IDLE) && fifo_empty && !uart_strobe;

  always_comb begin
    pop  = 1'b0;
    take = 1'b0;
    cand = 8'h00;
    if (state == IDLE) begin
      if (!fifo_empty) begin
        pop  = 1'b1;
        take = 1'b1;
        cand = fifo_head;
      end else if (auto_ready && auto_valid) begin
        take = 1'b1;
        cand = auto_data;
      end
    end
  end

`ifdef PET_KEY_SCHED_CRLF_EN
  // "Last byte taken was CR" per source. The flag follows the original byte,
  // so a LF converted to CR does not swallow a following LF.
  logic cr_uart, cr_auto;

  assign drop       = (cand == 8'h0A) && (pop ? cr_uart : cr_auto);
  assign issue_byte = (cand == 8'h0A) ? 8'h0D : cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      cr_uart <= 1'b0;
      cr_auto <= 1'b0;
    end else if (take) begin
      if (pop) begin
        cr_uart <= (cand == 8'h0D);
      end else begin
        cr_auto <= (cand == 8'h0D);
      end
    end
  end
`else
  assign drop       = 1'b0;
  assign issue_byte = cand;
`endif

  //---------------------------------------------------------------------------
  // Pacing counters
  //---------------------------------------------------------------------------
  logic [SW-1:0] scan_cnt, scan_next;
  logic [TW-1:0] tmo_cnt;
  logic          hold_done, tmo_done;

  assign scan_next = scan_cnt + SW'(wrap);
  // Leave WAIT on the very cycle the final wrap is seen.
  assign hold_done = (scan_next >= HOLD_C);
  assign tmo_done  = (tmo_cnt == TMO_LAST);

  //---------------------------------------------------------------------------
  // FSM
  //---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take && !drop) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (hold_done || tmo_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      key_data <= 8'h00;
      scan_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_next;
      if (take && !drop) begin
        key_data <= issue_byte;
      end
      if (state == ISSUE) begin
        scan_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (state == WAIT) begin
        scan_cnt <= scan_next;
        tmo_cnt  <= tmo_cnt + TW'(1);
      end
    end
  end

  assign key_strobe = (state == ISSUE);
  assign busy       = !fifo_empty || (state != IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_pet_key_sched.sv
//-----------------------------------------------------------------------------
// tb_pet_key_sched
//
// Directed bench for pet_key_sched. A free-running keyrow generator models
// the PET scan (ROW_CLKS clocks per row, rows 0..9) and can be frozen at
// 4'hf. A monitor records every key_strobe (data, cycle) and, for each WAIT
// period, how many frame wraps occurred between entering WAIT and leaving it.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pet_key_sched;

  localparam int FIFO_DEPTH   = 16;
  localparam int HOLD_SCANS   = 3;
  localparam int TIMEOUT_CLKS = 100;
  localparam int ROW_CLKS     = 2;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] uart_data;
  logic       uart_strobe;
  logic [7:0] auto_data;
  logic       auto_valid;
  logic       auto_ready;
  logic [3:0] keyrow;
  logic [7:0] key_data;
  logic       key_strobe;
  logic       busy;
  logic       overflow;
  logic [1:0] state_dbg;

  pet_key_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HOLD_SCANS  (HOLD_SCANS),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_data  (uart_data),
    .uart_strobe(uart_strobe),
    .auto_data  (auto_data),
    .auto_valid (auto_valid),
    .auto_ready (auto_ready),
    .keyrow     (keyrow),
    .key_data   (key_data),
    .key_strobe (key_strobe),
    .busy       (busy),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // counters
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc++;

  // keyrow generator
  logic scan_on = 1'b0;
  int   row_tick = 0;

  initial begin
    keyrow = 4'hf;
    forever begin
      @(negedge clk);
      if (scan_on) begin
        if (row_tick == ROW_CLKS - 1) begin
          row_tick = 0;
          keyrow = (keyrow >= 4'd9) ? 4'd0 : keyrow + 4'd1;
        end else begin
          row_tick++;
        end
      end else begin
        keyrow   = 4'hf;
        row_tick = 0;
      end
    end
  end

  // frame wrap counter (independent of the DUT)
  int         wraps = 0;
  logic [3:0] prev_kr = 4'hf;

  always @(posedge clk) begin
    if (prev_kr == 4'd9 && keyrow == 4'd0) wraps++;
    prev_kr = keyrow;
  end

  // strobe / hold monitor
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         obs_hold[$];
  logic       pend = 1'b0;
  logic       in_wait = 1'b0;
  int         wrap_snap = 0;

  always @(negedge clk) begin
    if (reset) begin
      pend    = 1'b0;
      in_wait = 1'b0;
    end else if (key_strobe) begin
      obs_data.push_back(key_data);
      obs_cyc.push_back(cyc);
      pend = 1'b1;
    end else if (pend) begin
      pend      = 1'b0;
      in_wait   = 1'b1;
      wrap_snap = wraps;
    end else if (in_wait && state_dbg != ST_WAIT) begin
      obs_hold.push_back(wraps - wrap_snap);
      in_wait = 1'b0;
    end
  end

  // scoreboard expected queue
  logic [7:0] exp_q[$];

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_cyc.delete();
    obs_hold.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b1;
    uart_strobe = 1'b0;
    auto_valid  = 1'b0;
    repeat (n) @(negedge clk);
    clear_obs();
    reset = 1'b0;
  endtask

  task automatic send_uart(input logic [7:0] b);
    uart_data   = b;
    uart_strobe = 1'b1;
    @(negedge clk);
    uart_strobe = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      uart_data   = base + 8'(i);
      uart_strobe = 1'b1;
      @(negedge clk);
    end
    uart_strobe = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check(tag, obs_data.size(), n);
  endtask

  task automatic wait_hold(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_hold.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check(tag, obs_hold.size(), n);
  endtask

  function automatic int cyc_at(input int i);
    return (obs_cyc.size() > i) ? obs_cyc[i] : -1;
  endfunction

  function automatic logic [7:0] data_at(input int i);
    return (obs_data.size() > i) ? obs_data[i] : 8'hxx;
  endfunction

  function automatic int hold_at(input int i);
    return (obs_hold.size() > i) ? obs_hold[i] : -1;
  endfunction

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // directed sequence
  initial begin
    int c0;
    int k;
    int n_exp;
    uart_data   = 8'h00;
    uart_strobe = 1'b0;
    auto_data   = 8'h00;
    auto_valid  = 1'b0;
    @(negedge clk);

    // reset state
    do_reset(20);
    check("rst_key_data", key_data, 8'h00);
    check("rst_key_strobe", key_strobe, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_auto_ready", auto_ready, 1'b1);

    // single key: latency 2, hold for 3 frames
    scan_on = 1'b1;
    repeat (30) @(negedge clk);
    c0 = cyc;
    send_uart(8'h0D);
    wait_strobes(1, 20, "single_strobe_cnt");
    check("single_latency", cyc_at(0) - c0, 2);
    check("single_data", data_at(0), 8'h0D);
    wait_hold(1, 200, "single_hold_done");
    check("single_hold_wraps", hold_at(0), HOLD_SCANS);
    repeat (2) @(negedge clk);
    check("single_busy_low", busy, 1'b0);
    check("single_key_held", key_data, 8'h0D);

    // pacing: three back-to-back bytes
    clear_obs();
    send_burst(3, 8'h41);
    wait_strobes(3, 400, "pace_strobe_cnt");
    wait_hold(3, 200, "pace_hold_cnt");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pace_data_%0d", i), data_at(i), 8'h41 + 8'(i));
      check($sformatf("pace_hold_%0d", i), hold_at(i), HOLD_SCANS);
    end
    check("pace_no_overflow", overflow, 1'b0);

    // overflow + timeout pacing with keyrow frozen
    do_reset(5);
    scan_on = 1'b0;
    repeat (3) @(negedge clk);
    send_burst(20, 8'h60);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h60 + 8'(i));
    wait_strobes(17, 17 * (TIMEOUT_CLKS + 2) + 50, "ovf_strobe_cnt");
    check("tmo_spacing_first", cyc_at(1) - cyc_at(0), TIMEOUT_CLKS + 2);
    check("tmo_spacing_last", cyc_at(16) - cyc_at(15), TIMEOUT_CLKS + 2);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("ovf_data_%0d", i), data_at(i), e);
    end
    repeat (TIMEOUT_CLKS * 2 + 50) @(negedge clk);
    check("ovf_no_extra", obs_data.size(), 17);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_busy_low", busy, 1'b0);

    // arbitration: UART and auto-type in the same cycle
    do_reset(5);
    check("arb_ovf_cleared", overflow, 1'b0);
    scan_on = 1'b1;
    repeat (5) @(negedge clk);
    auto_data   = 8'h31;
    auto_valid  = 1'b1;
    uart_data   = 8'h41;
    uart_strobe = 1'b1;
    @(negedge clk);
    uart_strobe = 1'b0;
    k = 0;
    while (!auto_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("arb_ready_seen", auto_ready, 1'b1);
    check("arb_uart_first_cnt", obs_data.size(), 1);
    check("arb_uart_first_data", data_at(0), 8'h41);
    check("arb_uart_hold_done", obs_hold.size(), 1);
    @(negedge clk);
    auto_valid = 1'b0;
    auto_data  = 8'hEE;
    #1;
    check("arb_ready_pulse", auto_ready, 1'b0);
    wait_strobes(2, 20, "arb_auto_cnt");
    check("arb_auto_data", data_at(1), 8'h31);
    wait_hold(2, 200, "arb_auto_hold");

    // reset in the middle of WAIT with a full FIFO
    scan_on = 1'b0;
    repeat (3) @(negedge clk);
    clear_obs();
    send_burst(20, 8'h80);
    repeat (10) @(negedge clk);
    check("midrst_pre_busy", busy, 1'b1);
    check("midrst_pre_ovf", overflow, 1'b1);
    do_reset(3);
    check("midrst_strobe", key_strobe, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_key_data", key_data, 8'h00);
    c0 = cyc;
    send_uart(8'h55);
    wait_strobes(1, 20, "midrst_strobe_cnt");
    check("midrst_latency", cyc_at(0) - c0, 2);
    check("midrst_data", data_at(0), 8'h55);
    repeat (TIMEOUT_CLKS + 20) @(negedge clk);
    check("midrst_flushed", obs_data.size(), 1);

    // CR / LF handling
    do_reset(5);
    scan_on = 1'b1;
    repeat (5) @(negedge clk);
`ifdef PET_KEY_SCHED_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0D);
`else
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0A);
`endif
    n_exp = exp_q.size();
    uart_data = 8'h0D; uart_strobe = 1'b1; @(negedge clk);
    uart_data = 8'h0A; @(negedge clk);
    uart_data = 8'h0A; @(negedge clk);
    uart_strobe = 1'b0;
    wait_strobes(n_exp, 600, "crlf_strobe_cnt");
    repeat (200) @(negedge clk);
    check("crlf_total", obs_data.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("crlf_data_%0d", i), data_at(i), e);
    end

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
